// File: rtl/reg_file_mp.sv
// Multi-port integer register file: two async read ports, two prioritised write
// ports, optional same-cycle forwarding and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  input  logic            wb_clr0,
  input  logic            wb_clr1
);

  localparam int NREG = 1 << AW;

  // No handshake on any port: every input is consumed on the clock edge it is
  // presented and every output is valid combinationally; there is no backpressure.

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic wr0_act, wr1_act, clr0_act, clr1_act, set_act;

  assign wr0_act  = we0 && (wa0 != '0);
  assign wr1_act  = we1 && (wa1 != '0);
  assign clr0_act = wr0_act && wb_clr0;
  assign clr1_act = wr1_act && wb_clr1;
  assign set_act  = iss_en && (iss_rd != '0);

  // Set is applied after the clears so a newly issued producer supersedes a completing one.
  always_comb begin
    busy_d = busy_q;
    if (clr0_act) busy_d[wa0] = 1'b0;
    if (clr1_act) busy_d[wa1] = 1'b0;
    if (set_act)  busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr0_act) regs_q[wa0] <= wd0;
      // Port 1 is assigned last so it wins a same-address collision.
      if (wr1_act) regs_q[wa1] <= wd1;
      busy_q <= busy_d;
    end
  end

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] ra);
    logic [XLEN-1:0] d;
    d = regs_q[ra];
    if (BYPASS != 0) begin
      if (wr0_act && (wa0 == ra)) d = wd0;
      if (wr1_act && (wa1 == ra)) d = wd1;
    end
    if (ra == '0) d = '0;
    return d;
  endfunction

  function automatic logic read_busy(input logic [AW-1:0] ra);
    logic b;
    b = busy_q[ra];
    if (BYPASS != 0) begin
      if (((clr0_act && (wa0 == ra)) || (clr1_act && (wa1 == ra))) &&
          !(set_act && (iss_rd == ra)))
        b = 1'b0;
    end
    if (ra == '0) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    rd1   = read_data(ra1);
    rd2   = read_data(ra2);
    busy1 = read_busy(ra1);
    busy2 = read_busy(ra2);
  end

endmodule
